// File: rtl/serial_cmd_sequencer_pkg.sv
// Shared serial definitions: idle-line codes, speed codes and the sequencer
// state encoding. The downstream serializer imports the same package so both
// ends agree on what each field value means.
package serial_cmd_sequencer_pkg;

    // Line level driven by the serializer between packets
    localparam logic [1:0] IDLE_LOW    = 2'b00;
    localparam logic [1:0] IDLE_HIGH   = 2'b01;
    localparam logic [1:0] IDLE_KEEP   = 2'b10;
    localparam logic [1:0] IDLE_REPEAT = 2'b11;

    // Bit-rate select
    localparam logic LOW_SPEED  = 1'b0;
    localparam logic HIGH_SPEED = 1'b1;

    // Command sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } seq_state_t;

endpackage

// File: rtl/serial_cmd_sequencer_cmd_fifo.sv
// Small synchronous command FIFO. Pointers wrap naturally because DEPTH is a
// power of two; the separate occupancy counter tells full from empty.
// A flush clears pointers and count and wins over any push/pop that cycle.
module cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  logic [WIDTH-1:0]        push_data,
    input  logic                    pop,
    output logic [WIDTH-1:0]        head_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign push_ok   = push && !full && !flush;
    assign pop_ok    = pop && !empty && !flush;
    assign head_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (pop_ok && !push_ok) begin
                count <= count - 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/serial_cmd_sequencer.sv
// Command sequencer in front of a serializer: queues host commands, hands
// them out one at a time with a start pulse, waits for the serializer's done
// tick (bounded by a timeout), and leaves a fixed idle gap between packets.
// An abort flushes the queue and stops the serializer if it was engaged.
module serial_cmd_sequencer
    import serial_cmd_sequencer_pkg::*;
#(
    parameter int DATA_BIT    = 8,
    parameter int DEPTH       = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [DATA_BIT-1:0]     wr_data,
    input  logic                    wr_sel_freq,
    input  logic [1:0]              wr_idle_mode,
    input  logic                    i_abort,
    input  logic                    i_done_tick,
    output logic                    o_start,
    output logic                    o_stop,
    output logic [DATA_BIT-1:0]     o_data,
    output logic                    o_sel_freq,
    output logic [1:0]              o_idle_mode,
    output logic                    o_busy,
    output logic [$clog2(DEPTH):0]  o_count,
    output logic                    o_pkt_done_tick,
    output logic                    o_timeout_tick
);

    localparam int CMD_W = DATA_BIT + 3;
    localparam int TO_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [TO_W-1:0]     wait_cnt;
    logic [TO_W-1:0]     wait_cnt_nxt;
    logic [GAP_W-1:0]    gap_cnt;
    logic [GAP_W-1:0]    gap_cnt_nxt;
    logic                start_nxt;
    logic                stop_nxt;
    logic                done_nxt;
    logic                timeout_nxt;
    logic                load_en;

    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CMD_W-1:0]    fifo_head;

    assign wr_ready  = !fifo_full && !i_abort;
    assign fifo_push = wr_valid && wr_ready;
    assign o_busy    = (state != ST_IDLE) || !fifo_empty;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (i_abort),
        .push      (fifo_push),
        .push_data ({wr_data, wr_sel_freq, wr_idle_mode}),
        .pop       (load_en),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (o_count)
    );

    // Next-state and pulse decode; abort overrides everything
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = '0;
        gap_cnt_nxt  = '0;
        start_nxt    = 1'b0;
        stop_nxt     = 1'b0;
        done_nxt     = 1'b0;
        timeout_nxt  = 1'b0;
        load_en      = 1'b0;
        if (i_abort) begin
            state_nxt = ST_IDLE;
            stop_nxt  = (state != ST_IDLE);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    load_en   = 1'b1;
                    start_nxt = 1'b1;
                    state_nxt = ST_START;
                end
                ST_START: begin
                    state_nxt = ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i_done_tick) begin
                        done_nxt  = 1'b1;
                        state_nxt = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                    end else if (wait_cnt == TO_LAST) begin
                        stop_nxt    = 1'b1;
                        timeout_nxt = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        gap_cnt_nxt = gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered one-cycle pulses
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            gap_cnt         <= '0;
            o_start         <= 1'b0;
            o_stop          <= 1'b0;
            o_pkt_done_tick <= 1'b0;
            o_timeout_tick  <= 1'b0;
        end else begin
            state           <= state_nxt;
            wait_cnt        <= wait_cnt_nxt;
            gap_cnt         <= gap_cnt_nxt;
            o_start         <= start_nxt;
            o_stop          <= stop_nxt;
            o_pkt_done_tick <= done_nxt;
            o_timeout_tick  <= timeout_nxt;
        end
    end

    // Command fields held for the serializer from one load to the next
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            o_data      <= '0;
            o_sel_freq  <= LOW_SPEED;
            o_idle_mode <= IDLE_LOW;
        end else if (load_en) begin
            {o_data, o_sel_freq, o_idle_mode} <= fifo_head;
        end
    end

endmodule

// File: tb/tb_serial_cmd_sequencer.sv
// Bench for serial_cmd_sequencer: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level timing model.
module tb_serial_cmd_sequencer;

    localparam int DATA_BIT    = 8;
    localparam int DEPTH       = 4;
    localparam int GAP_CYCLES  = 2;
    localparam int TIMEOUT_CYC = 40;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    wr_valid;
    logic                    wr_ready;
    logic [DATA_BIT-1:0]     wr_data;
    logic                    wr_sel_freq;
    logic [1:0]              wr_idle_mode;
    logic                    i_abort;
    logic                    i_done_tick;
    logic                    o_start;
    logic                    o_stop;
    logic [DATA_BIT-1:0]     o_data;
    logic                    o_sel_freq;
    logic [1:0]              o_idle_mode;
    logic                    o_busy;
    logic [$clog2(DEPTH):0]  o_count;
    logic                    o_pkt_done_tick;
    logic                    o_timeout_tick;

    always #5 clk = ~clk;

    serial_cmd_sequencer #(
        .DATA_BIT    (DATA_BIT),
        .DEPTH       (DEPTH),
        .GAP_CYCLES  (GAP_CYCLES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .wr_valid        (wr_valid),
        .wr_ready        (wr_ready),
        .wr_data         (wr_data),
        .wr_sel_freq     (wr_sel_freq),
        .wr_idle_mode    (wr_idle_mode),
        .i_abort         (i_abort),
        .i_done_tick     (i_done_tick),
        .o_start         (o_start),
        .o_stop          (o_stop),
        .o_data          (o_data),
        .o_sel_freq      (o_sel_freq),
        .o_idle_mode     (o_idle_mode),
        .o_busy          (o_busy),
        .o_count         (o_count),
        .o_pkt_done_tick (o_pkt_done_tick),
        .o_timeout_tick  (o_timeout_tick)
    );

    // Reference model: queued commands with the edge they were accepted on,
    // plus the edge the current packet starts and the edge the line is free.
    typedef struct {
        logic [DATA_BIT-1:0] data;
        logic                sel;
        logic [1:0]          idle;
        int                  pushEdge;
    } cmd_t;

    cmd_t                cmdQ[$];
    cmd_t                curCmd;
    int                  edgeNow;
    bit                  engaged;
    int                  startEdge;
    int                  freeEdge;
    logic                expStart;
    logic                expStop;
    logic                expDoneTick;
    logic                expTimeout;
    logic [DATA_BIT-1:0] expData;
    logic                expSel;
    logic [1:0]          expIdle;

    int                  vectors;
    int                  miscompares;
    logic [DATA_BIT:0]   startLog[$];
    int                  lastStartEdge;
    int                  timeoutSeen;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at edge %0d: observed 0x%0h, expected 0x%0h", tag, edgeNow, observed, expected);
        end
    endtask

    task automatic modelReset();
        cmdQ.delete();
        engaged     = 1'b0;
        freeEdge    = edgeNow;
        expStart    = 1'b0;
        expStop     = 1'b0;
        expDoneTick = 1'b0;
        expTimeout  = 1'b0;
        expData     = '0;
        expSel      = 1'b0;
        expIdle     = 2'b00;
    endtask

    // Advance the model by one clock edge given the inputs sampled on it
    task automatic modelEdge(input logic v, input logic [DATA_BIT-1:0] d, input logic s,
                             input logic [1:0] im, input logic a, input logic dn);
        bit   accept;
        cmd_t c;
        accept      = v && !a && (cmdQ.size() < DEPTH);
        edgeNow++;
        expStart    = 1'b0;
        expStop     = 1'b0;
        expDoneTick = 1'b0;
        expTimeout  = 1'b0;
        if (a) begin
            expStop  = engaged || (edgeNow <= freeEdge);
            engaged  = 1'b0;
            cmdQ.delete();
            freeEdge = edgeNow;
        end else begin
            if (engaged) begin
                if (edgeNow == startEdge) begin
                    curCmd   = cmdQ.pop_front();
                    expStart = 1'b1;
                    expData  = curCmd.data;
                    expSel   = curCmd.sel;
                    expIdle  = curCmd.idle;
                end else if (edgeNow >= startEdge + 2) begin
                    if (dn) begin
                        expDoneTick = 1'b1;
                        engaged     = 1'b0;
                        freeEdge    = edgeNow + GAP_CYCLES;
                    end else if (edgeNow == startEdge + 1 + TIMEOUT_CYC) begin
                        expStop    = 1'b1;
                        expTimeout = 1'b1;
                        engaged    = 1'b0;
                        freeEdge   = edgeNow;
                    end
                end
            end else if (cmdQ.size() > 0 && cmdQ[0].pushEdge <= edgeNow - 1 && freeEdge <= edgeNow - 1) begin
                engaged   = 1'b1;
                startEdge = edgeNow + 1;
            end
            if (accept) begin
                c.data     = d;
                c.sel      = s;
                c.idle     = im;
                c.pushEdge = edgeNow;
                cmdQ.push_back(c);
            end
        end
    endtask

    task automatic compareAll();
        checkOutput("o_start", o_start, expStart);
        checkOutput("o_stop", o_stop, expStop);
        checkOutput("o_pkt_done_tick", o_pkt_done_tick, expDoneTick);
        checkOutput("o_timeout_tick", o_timeout_tick, expTimeout);
        checkOutput("o_busy", o_busy, engaged || (edgeNow < freeEdge) || (cmdQ.size() != 0));
        checkOutput("o_count", o_count, cmdQ.size());
        checkOutput("o_data", o_data, expData);
        checkOutput("o_sel_freq", o_sel_freq, expSel);
        checkOutput("o_idle_mode", o_idle_mode, expIdle);
        if (o_start === 1'b1) begin
            startLog.push_back({o_sel_freq, o_data});
            lastStartEdge = edgeNow;
        end
        if (o_timeout_tick === 1'b1) begin
            timeoutSeen++;
        end
    endtask

    // Drive one cycle of inputs, clock it, and compare the results
    task automatic applyStimulus(input logic v, input logic [DATA_BIT-1:0] d, input logic s,
                                 input logic [1:0] im, input logic a, input logic dn);
        wr_valid     = v;
        wr_data      = d;
        wr_sel_freq  = s;
        wr_idle_mode = im;
        i_abort      = a;
        i_done_tick  = dn;
        #1;
        checkOutput("wr_ready", wr_ready, (cmdQ.size() < DEPTH) && !a);
        @(posedge clk);
        modelEdge(v, d, s, im, a, dn);
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycles(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
    endtask

    task automatic pushCmd(input logic [DATA_BIT-1:0] d, input logic s, input logic [1:0] im);
        bit accepted;
        for (int k = 0; k < 200; k++) begin
            accepted = (cmdQ.size() < DEPTH);
            applyStimulus(1'b1, d, s, im, 1'b0, 1'b0);
            if (accepted) break;
        end
    endtask

    // Step until the current packet has been waiting 'extra' cycles for done
    task automatic waitInFlight(input int extra);
        for (int k = 0; k < 300; k++) begin
            if (engaged && edgeNow >= startEdge + 1 + extra) break;
            applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
    endtask

    task automatic completeCurrent(input int extra);
        waitInFlight(extra);
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic doReset();
        #2 rst_n = 1'b1;
        #1;
        checkOutput("rst_o_start", o_start, 1'b0);
        checkOutput("rst_o_stop", o_stop, 1'b0);
        checkOutput("rst_o_data", o_data, '0);
        checkOutput("rst_o_sel_freq", o_sel_freq, 1'b0);
        checkOutput("rst_o_idle_mode", o_idle_mode, 2'b00);
        checkOutput("rst_o_busy", o_busy, 1'b0);
        checkOutput("rst_o_count", o_count, '0);
        checkOutput("rst_o_pkt_done", o_pkt_done_tick, 1'b0);
        checkOutput("rst_o_timeout", o_timeout_tick, 1'b0);
        @(posedge clk);
        edgeNow++;
        @(negedge clk);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_wr_ready", wr_ready, 1'b1);
        checkOutput("rst_count_after", o_count, '0);
    endtask

    logic [DATA_BIT:0] expSeq [5];
    int                doneEdge;
    int                startsBefore;
    int                timeoutsBefore;

    initial begin
        vectors       = 0;
        miscompares   = 0;
        edgeNow       = 0;
        lastStartEdge = 0;
        timeoutSeen   = 0;
        wr_valid      = 1'b0;
        wr_data       = '0;
        wr_sel_freq   = 1'b0;
        wr_idle_mode  = 2'b00;
        i_abort       = 1'b0;
        i_done_tick   = 1'b0;
        rst_n         = 1'b1;
        modelReset();

        // Reset state
        repeat (3) @(negedge clk);
        doReset();

        // Single command into an empty queue: start two edges after the push
        $display("[TB] single command");
        pushCmd(8'h55, 1'b1, 2'b01);
        idleCycles(2);
        checkOutput("single_start", o_start, 1'b1);
        checkOutput("single_data", o_data, 8'h55);
        completeCurrent(5);
        checkOutput("single_done_tick", o_pkt_done_tick, 1'b1);
        idleCycles(GAP_CYCLES + 3);

        // Back-to-back commands: queue fills, order kept, fixed inter-packet spacing
        $display("[TB] back-to-back commands");
        startLog.delete();
        expSeq[0] = {1'b1, 8'h55};
        expSeq[1] = {1'b0, 8'hAA};
        expSeq[2] = {1'b1, 8'h55};
        expSeq[3] = {1'b0, 8'hAA};
        expSeq[4] = {1'b1, 8'hF0};
        for (int k = 0; k < 5; k++) begin
            pushCmd(expSeq[k][DATA_BIT-1:0], expSeq[k][DATA_BIT], 2'(k));
        end
        checkOutput("b2b_full_count", o_count, DEPTH);
        applyStimulus(1'b1, 8'h77, 1'b0, 2'b00, 1'b0, 1'b0);
        checkOutput("b2b_dropped_count", o_count, DEPTH);
        doneEdge = 0;
        for (int k = 0; k < 5; k++) begin
            waitInFlight(1 + k);
            if (k > 0) begin
                checkOutput("b2b_gap", lastStartEdge - doneEdge, GAP_CYCLES + 2);
            end
            applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b0, 1'b1);
            doneEdge = edgeNow;
        end
        idleCycles(GAP_CYCLES + 4);
        checkOutput("b2b_nstarts", startLog.size(), 5);
        for (int k = 0; k < 5; k++) begin
            if (k < startLog.size()) begin
                checkOutput("b2b_order", startLog[k], expSeq[k]);
            end
        end

        // Abort while waiting for done with three entries queued
        $display("[TB] abort in flight");
        for (int k = 0; k < 4; k++) begin
            pushCmd(8'(8'h10 + k), 1'b0, 2'b10);
        end
        waitInFlight(0);
        checkOutput("abort_queued", o_count, 3);
        applyStimulus(1'b0, '0, 1'b0, 2'b00, 1'b1, 1'b0);
        checkOutput("abort_stop", o_stop, 1'b1);
        checkOutput("abort_count", o_count, 0);
        startsBefore = startLog.size();
        idleCycles(20);
        checkOutput("abort_no_start", startLog.size(), startsBefore);

        // Done withheld: timeout, then the next queued entry goes out
        $display("[TB] timeout");
        pushCmd(8'hC3, 1'b1, 2'b11);
        pushCmd(8'h3C, 1'b0, 2'b00);
        waitInFlight(0);
        timeoutsBefore = timeoutSeen;
        startsBefore   = startLog.size();
        idleCycles(TIMEOUT_CYC + 5);
        checkOutput("timeout_seen", timeoutSeen, timeoutsBefore + 1);
        checkOutput("timeout_next_start", startLog.size(), startsBefore + 1);
        completeCurrent(2);
        idleCycles(GAP_CYCLES + 3);

        // Write colliding with abort is dropped
        $display("[TB] write with abort");
        applyStimulus(1'b1, 8'h3C, 1'b1, 2'b11, 1'b1, 1'b0);
        checkOutput("wrabort_count", o_count, 0);
        checkOutput("wrabort_busy", o_busy, 1'b0);
        idleCycles(3);

        // Reset in the middle of a packet
        $display("[TB] reset mid-packet");
        for (int k = 0; k < 3; k++) begin
            pushCmd(8'(8'hA0 + k), 1'b1, 2'b01);
        end
        waitInFlight(2);
        doReset();
        idleCycles(5);

        // Random traffic
        $display("[TB] random traffic");
        for (int k = 0; k < 2500; k++) begin
            applyStimulus($urandom_range(0, 99) < 35,
                          DATA_BIT'($urandom),
                          1'($urandom),
                          2'($urandom),
                          $urandom_range(0, 199) < 3,
                          $urandom_range(0, 99) < 6);
        end
        idleCycles(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_cmd_sequencer.md
SERIAL_CMD_SEQUENCER -- requirements
Module: serial_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_BIT, default 8: serial payload width, matching the downstream serializer.
REQ-002 SHALL have parameter DEPTH, default 4: command FIFO entries; power of 2, at least 2.
REQ-003 SHALL have parameter GAP_CYCLES, default 2: idle clocks inserted between consecutive packets; 0 is legal.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 4096: maximum clocks spent waiting for the serializer done tick.
REQ-005 SHALL have port clk, input, 1 bit: system clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port wr_valid, input, 1 bit: host command write request.
REQ-008 SHALL have port wr_ready, output, 1 bit: sequencer accepts a command this cycle.
REQ-009 SHALL have port wr_data, input, DATA_BIT bits: payload.
REQ-010 SHALL have port wr_sel_freq, input, 1 bit: 0 = low speed, 1 = high speed.
REQ-011 SHALL have port wr_idle_mode, input, 2 bits: 00 low, 01 high, 10 keep, 11 repeat.
REQ-012 SHALL have port i_abort, input, 1 bit: flush the FIFO and stop the serializer.
REQ-013 SHALL have port i_done_tick, input, 1 bit: serializer transmission-complete tick.
REQ-014 SHALL have ports o_start, output, 1 bit, and o_stop, output, 1 bit: one-cycle pulses to the serializer.
REQ-015 SHALL have ports o_data (DATA_BIT bits), o_sel_freq (1 bit) and o_idle_mode (2 bits), all outputs: registered command fields to the serializer.
REQ-016 SHALL have ports o_busy (1 bit), o_count ($clog2(DEPTH)+1 bits), o_pkt_done_tick (1 bit) and o_timeout_tick (1 bit), all outputs: status.

Function
REQ-017 SHALL store {data, sel_freq, idle_mode} entries in a FIFO; a push occurs when wr_valid && wr_ready.
REQ-018 SHALL drive wr_ready = !full && !i_abort; there is no bypass path, so a push and a pop in the same cycle while full is impossible.
REQ-019 SHALL implement an FSM with states IDLE, LOAD, START, WAIT_DONE and GAP.
REQ-020 SHALL move from IDLE to LOAD when the FIFO is not empty; in LOAD it pops the head entry into the o_data, o_sel_freq and o_idle_mode registers.
REQ-021 SHALL assert o_start for exactly one cycle in START, one clock after LOAD, and then enter WAIT_DONE.
REQ-022 SHALL hold o_data, o_sel_freq and o_idle_mode stable from LOAD until the next LOAD.
REQ-023 SHALL, in WAIT_DONE on i_done_tick, pulse o_pkt_done_tick in the following cycle and enter GAP, or enter IDLE when GAP_CYCLES == 0.
REQ-024 SHALL stay in GAP for exactly GAP_CYCLES clocks and then enter IDLE; a queued entry then gives LOAD in the next cycle.
REQ-025 SHALL, when WAIT_DONE lasts TIMEOUT_CYC clocks without i_done_tick, pulse o_stop and o_timeout_tick together and go to IDLE with the FIFO retained.
REQ-026 SHALL, when i_abort is high in any state, pulse o_stop next cycle (unless in IDLE), empty the FIFO, go to IDLE, and drop any same-cycle write.
REQ-027 SHALL ignore i_done_tick outside WAIT_DONE.
REQ-028 SHALL drive o_busy high in every state except IDLE, or while the FIFO is non-empty.
REQ-029 SHALL drive o_count as the FIFO occupancy, 0..DEPTH; read and write pointers wrap modulo DEPTH.

Reset
REQ-030 SHALL, while rst_n is asserted, clear the FSM to IDLE, the FIFO pointers and count to 0, and all counters to 0.
REQ-031 SHALL reset o_start, o_stop, o_data, o_sel_freq, o_idle_mode (to 00), o_busy, o_pkt_done_tick and o_timeout_tick to 0.
REQ-032 SHALL drive wr_ready = 1 after reset is released.
REQ-033 SHALL, on a reset mid-transmission, discard all queued commands and issue no o_stop.

Structure
REQ-034 SHALL define the idle-mode codes (IDLE_LOW, IDLE_HIGH, IDLE_KEEP, IDLE_REPEAT), the speed codes (LOW_SPEED, HIGH_SPEED) and the FSM state encoding in a shared serial package, also used by the serializer.
REQ-035 SHALL place the FIFO in one sub-module, cmd_fifo, parameterised by width and DEPTH.

Verification
REQ-036 SHALL cover: push 55/HIGH/IDLE_HIGH into an empty FIFO -> o_start exactly 2 cycles after the push, o_data=0x55 and o_sel_freq=1 held until done.
REQ-037 SHALL cover: push 55/H, AA/L, 55/H, AA/L, F0/H back-to-back -> wr_ready low after 4 entries, 5 o_start pulses in order, GAP_CYCLES+2 clocks from each i_done_tick to the next o_start.
REQ-038 SHALL cover: i_abort during WAIT_DONE with 3 entries queued -> one o_stop pulse, o_count=0, no further o_start.
REQ-039 SHALL cover: i_done_tick withheld -> o_stop and o_timeout_tick after TIMEOUT_CYC clocks, then the next entry starts.
REQ-040 SHALL cover: wr_valid and i_abort in the same cycle -> write dropped, o_count=0.
REQ-041 SHALL cover: rst_n pulsed mid-packet -> all outputs 0, o_count=0, wr_ready=1 after release.
